// File: rtl/handshake_fxp_mul_pipe_if.sv
// Elastic operand/result channels for handshake_fxp_mul_pipe.
// The master side drives operands and result_ready; the slave side is the multiplier.
interface handshake_fxp_mul_pipe_if #(
    parameter int DATA_WIDTH = 18
);
    logic [DATA_WIDTH-1:0] lhs;
    logic                  lhs_valid;
    logic                  lhs_ready;
    logic [DATA_WIDTH-1:0] rhs;
    logic                  rhs_valid;
    logic                  rhs_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  result_valid;
    logic                  result_ready;

    modport master (
        output lhs, lhs_valid, rhs, rhs_valid, result_ready,
        input  lhs_ready, rhs_ready, result, result_valid
    );

    modport slave (
        input  lhs, lhs_valid, rhs, rhs_valid, result_ready,
        output lhs_ready, rhs_ready, result, result_valid
    );
endinterface

// File: rtl/handshake_fxp_mul_pipe.sv
// Elastic signed fixed-point multiplier: join, 3-stage bubble-collapsing pipe, round half up.
// Define HANDSHAKE_FXP_MUL_SAT_EN to saturate the result; otherwise it wraps to DATA_WIDTH.
module handshake_fxp_mul_pipe #(
    parameter int DATA_WIDTH = 18,
    parameter int FRAC_BITS  = 10
) (
    input logic                     clk,
    input logic                     rst,
    handshake_fxp_mul_pipe_if.slave bus
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int RW = PW + 1;
    localparam logic signed [RW-1:0] ROUND_C = RW'(1) <<< (FRAC_BITS - 1);

    logic                         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [DATA_WIDTH-1:0] s1Lhs_q, s1Lhs_d, s1Rhs_q, s1Rhs_d;
    logic signed [PW-1:0]         s2Prod_q, s2Prod_d;
    logic [DATA_WIDTH-1:0]        s3Res_q, s3Res_d;
    logic                         s1Ready, s2Ready, s3Ready, fire;
    logic signed [RW-1:0]         roundedFull;
    logic [DATA_WIDTH-1:0]        narrowed;

    // Ready ripples back from the sink so a full pipe still moves 1 token/cycle.
    assign s3Ready = ~v3_q | bus.result_ready;
    assign s2Ready = ~v2_q | s3Ready;
    assign s1Ready = ~v1_q | s2Ready;

    assign fire          = bus.lhs_valid & bus.rhs_valid & s1Ready;
    assign bus.lhs_ready = bus.rhs_valid & s1Ready;
    assign bus.rhs_ready = bus.lhs_valid & s1Ready;
    assign bus.result       = s3Res_q;
    assign bus.result_valid = v3_q;

    // One guard bit keeps the rounding add from overflowing the product width.
    assign roundedFull = ($signed({s2Prod_q[PW-1], s2Prod_q}) + ROUND_C) >>> FRAC_BITS;

`ifdef HANDSHAKE_FXP_MUL_SAT_EN
    localparam logic signed [RW-1:0] MAX_C = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_C = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        if (roundedFull > MAX_C) begin
            narrowed = MAX_C[DATA_WIDTH-1:0];
        end else if (roundedFull < MIN_C) begin
            narrowed = MIN_C[DATA_WIDTH-1:0];
        end else begin
            narrowed = roundedFull[DATA_WIDTH-1:0];
        end
    end
`else
    logic unusedHighBits;

    assign narrowed       = roundedFull[DATA_WIDTH-1:0];
    assign unusedHighBits = ^roundedFull[RW-1:DATA_WIDTH];
`endif

    always_comb begin
        v1_d     = v1_q;
        v2_d     = v2_q;
        v3_d     = v3_q;
        s1Lhs_d  = s1Lhs_q;
        s1Rhs_d  = s1Rhs_q;
        s2Prod_d = s2Prod_q;
        s3Res_d  = s3Res_q;

        if (s1Ready) begin
            v1_d = fire;
        end
        if (fire) begin
            s1Lhs_d = bus.lhs;
            s1Rhs_d = bus.rhs;
        end

        if (s2Ready) begin
            v2_d = v1_q;
        end
        if (s2Ready & v1_q) begin
            s2Prod_d = s1Lhs_q * s1Rhs_q;
        end

        if (s3Ready) begin
            v3_d = v2_q;
        end
        if (s3Ready & v2_q) begin
            s3Res_d = narrowed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            s1Lhs_q  <= '0;
            s1Rhs_q  <= '0;
            s2Prod_q <= '0;
            s3Res_q  <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            s1Lhs_q  <= s1Lhs_d;
            s1Rhs_q  <= s1Rhs_d;
            s2Prod_q <= s2Prod_d;
            s3Res_q  <= s3Res_d;
        end
    end
endmodule

// File: tb/tb_handshake_fxp_mul_pipe.sv
// Directed bench for handshake_fxp_mul_pipe: latency, rounding, narrowing, join, backpressure, reset.
// Expected narrowing results follow HANDSHAKE_FXP_MUL_SAT_EN when it is defined for the build.
module tb_handshake_fxp_mul_pipe;
    logic clk;
    logic rst;
    int   vectorCount;
    int   missCount;

    handshake_fxp_mul_pipe_if #(.DATA_WIDTH(18)) bus ();

    handshake_fxp_mul_pipe #(
        .DATA_WIDTH(18),
        .FRAC_BITS (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int resultVal();
        return int'($signed(bus.result));
    endfunction

    // Fires one token into an empty pipe and checks the N+2 latency and the value.
    task automatic applyStimulus(input string tag, input int l, input int r, input int expected);
        @(negedge clk);
        bus.lhs          = 18'(l);
        bus.rhs          = 18'(r);
        bus.lhs_valid    = 1'b1;
        bus.rhs_valid    = 1'b1;
        bus.result_ready = 1'b1;
        #1;
        checkOutput({tag, "_lhsReady"}, int'(bus.lhs_ready), 1);
        @(negedge clk);
        bus.lhs_valid = 1'b0;
        bus.rhs_valid = 1'b0;
        checkOutput({tag, "_rvAfterN"}, int'(bus.result_valid), 0);
        @(negedge clk);
        checkOutput({tag, "_rvAfterN1"}, int'(bus.result_valid), 0);
        @(negedge clk);
        checkOutput({tag, "_rvAfterN2"}, int'(bus.result_valid), 1);
        checkOutput({tag, "_result"}, resultVal(), expected);
        @(negedge clk);
        checkOutput({tag, "_drained"}, int'(bus.result_valid), 0);
    endtask

    initial begin
        vectorCount      = 0;
        missCount        = 0;
        rst              = 1'b1;
        bus.lhs          = '0;
        bus.rhs          = '0;
        bus.lhs_valid    = 1'b0;
        bus.rhs_valid    = 1'b1;
        bus.result_ready = 1'b0;

        #2;
        checkOutput("rst_resultValid", int'(bus.result_valid), 0);
        checkOutput("rst_result", resultVal(), 0);
        checkOutput("rst_lhsReady", int'(bus.lhs_ready), 1);
        checkOutput("rst_rhsReadyNoLhs", int'(bus.rhs_ready), 0);
        bus.rhs_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postRst_resultValid", int'(bus.result_valid), 0);

        applyStimulus("mulByOne", -946, 1024, -946);
        applyStimulus("negSquare", -946, -946, 874);
        applyStimulus("halfRoundsUp", -1, 512, 0);
        applyStimulus("posRound", 3, 1536, 5);
`ifdef HANDSHAKE_FXP_MUL_SAT_EN
        applyStimulus("maxSquare", 131071, 131071, 131071);
        applyStimulus("minTimesMax", -131072, 131071, -131072);
`else
        applyStimulus("maxSquare", 131071, 131071, -256);
        applyStimulus("minTimesMax", -131072, 131071, 128);
`endif

        // Join: lhs alone must not be accepted.
        @(negedge clk);
        bus.lhs          = 18'(5);
        bus.rhs          = 18'(1024);
        bus.lhs_valid    = 1'b1;
        bus.rhs_valid    = 1'b0;
        bus.result_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("join_lhsReadyLow", int'(bus.lhs_ready), 0);
            checkOutput("join_noToken", int'(bus.result_valid), 0);
            @(negedge clk);
        end
        bus.rhs_valid = 1'b1;
        #1;
        checkOutput("join_lhsReady", int'(bus.lhs_ready), 1);
        checkOutput("join_rhsReady", int'(bus.rhs_ready), 1);
        @(negedge clk);
        bus.lhs_valid = 1'b0;
        bus.rhs_valid = 1'b0;
        #1;
        checkOutput("join_lhsReadyDrop", int'(bus.lhs_ready), 0);
        checkOutput("join_rhsReadyDrop", int'(bus.rhs_ready), 0);
        repeat (2) @(negedge clk);
        checkOutput("join_resultValid", int'(bus.result_valid), 1);
        checkOutput("join_result", resultVal(), 5);
        @(negedge clk);
        checkOutput("join_noDuplicate", int'(bus.result_valid), 0);

        // Backpressure: three tokens fill the pipe, the fourth waits.
        bus.result_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.lhs       = 18'(k);
            bus.rhs       = 18'(1024);
            bus.lhs_valid = 1'b1;
            bus.rhs_valid = 1'b1;
            #1;
            checkOutput($sformatf("bp_lhsReady%0d", k), int'(bus.lhs_ready), (k < 4) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_stallLhsReady", int'(bus.lhs_ready), 0);
            checkOutput("bp_stallRhsReady", int'(bus.rhs_ready), 0);
            checkOutput("bp_stallValid", int'(bus.result_valid), 1);
            checkOutput("bp_stallResult", resultVal(), 1);
        end
        bus.result_ready = 1'b1;
        #1;
        checkOutput("bp_releaseReady", int'(bus.lhs_ready), 1);
        checkOutput("bp_out1", resultVal(), 1);
        @(negedge clk);
        bus.lhs_valid = 1'b0;
        bus.rhs_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            checkOutput($sformatf("bp_valid%0d", k), int'(bus.result_valid), 1);
            checkOutput($sformatf("bp_out%0d", k), resultVal(), k);
            @(negedge clk);
        end
        checkOutput("bp_drained", int'(bus.result_valid), 0);

        // Reset with two tokens in flight discards them.
        bus.result_ready = 1'b0;
        for (int k = 7; k <= 8; k++) begin
            @(negedge clk);
            bus.lhs       = 18'(k);
            bus.rhs       = 18'(1024);
            bus.lhs_valid = 1'b1;
            bus.rhs_valid = 1'b1;
        end
        @(negedge clk);
        bus.lhs_valid = 1'b0;
        bus.rhs_valid = 1'b0;
        @(negedge clk);
        checkOutput("midRst_before", resultVal(), 7);
        rst = 1'b1;
        #1;
        checkOutput("midRst_validCleared", int'(bus.result_valid), 0);
        checkOutput("midRst_resultCleared", resultVal(), 0);
        @(negedge clk);
        rst              = 1'b0;
        bus.result_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("midRst_noReplay", int'(bus.result_valid), 0);
        end
        applyStimulus("afterRst", 9, 1024, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
